// File: rtl/vp_pkg.sv
// vp_pkg: shared types, widths and PC decode helpers for the stride value predictor.
package vp_pkg;
    localparam int VP_ADDR_WIDTH  = 32;
    localparam int VP_DATA_WIDTH  = 32;
    localparam int VP_INDEX_WIDTH = 6;
    localparam int VP_TAG_WIDTH   = VP_ADDR_WIDTH - VP_INDEX_WIDTH - 2;
    localparam int VP_CONF_WIDTH  = 2;
    localparam logic [VP_CONF_WIDTH-1:0] CONF_MAX = '1;

    typedef struct packed {
        logic                     valid;
        logic [VP_TAG_WIDTH-1:0]  tag;
        logic [VP_DATA_WIDTH-1:0] last_value;
        logic [VP_DATA_WIDTH-1:0] stride;
        logic [VP_CONF_WIDTH-1:0] conf;
    } vp_entry_t;

    function automatic logic [VP_INDEX_WIDTH-1:0] vp_index(input logic [VP_ADDR_WIDTH-1:0] pc);
        return pc[VP_INDEX_WIDTH+1:2];
    endfunction

    function automatic logic [VP_TAG_WIDTH-1:0] vp_tag(input logic [VP_ADDR_WIDTH-1:0] pc);
        return pc[VP_ADDR_WIDTH-1:VP_INDEX_WIDTH+2];
    endfunction
endpackage

// File: rtl/vp_sat_counter.sv
// vp_sat_counter: next-value logic for a saturating up-counter with synchronous clear.
module vp_sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] cnt,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] nxt
);
    always_comb begin
        nxt = clr ? '0 : (inc && cnt != '1) ? cnt + W'(1) : cnt;
    end
endmodule

// File: rtl/vp_stride_table.sv
// vp_stride_table: direct-mapped last-value/stride load value predictor.
// Lookups see pre-training contents; flush wins over a same-cycle train.
module vp_stride_table
    import vp_pkg::*;
#(
    parameter int INDEX_WIDTH = VP_INDEX_WIDTH,
    parameter int CONF_WIDTH  = VP_CONF_WIDTH,
    parameter int CONF_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     lookup_valid,
    input  logic [VP_ADDR_WIDTH-1:0] lookup_pc,
    output logic                     pred_valid,
    output logic [VP_DATA_WIDTH-1:0] pred_value,
    output logic                     pred_confident,
    output logic                     pred_hit,
    input  logic                     train_valid,
    input  logic [VP_ADDR_WIDTH-1:0] train_pc,
    input  logic [VP_DATA_WIDTH-1:0] train_value
);
    localparam int ENTRIES = 2 ** INDEX_WIDTH;

    vp_entry_t entries_q [ENTRIES];
    vp_entry_t entries_d [ENTRIES];

    logic                     pred_valid_q, pred_valid_d;
    logic                     pred_hit_q, pred_hit_d;
    logic                     pred_confident_q, pred_confident_d;
    logic [VP_DATA_WIDTH-1:0] pred_value_q, pred_value_d;

    logic [INDEX_WIDTH-1:0]   l_idx, t_idx;
    vp_entry_t                l_ent, t_ent;
    logic                     l_hit, t_hit, stride_same;
    logic [VP_DATA_WIDTH-1:0] new_stride;
    logic [CONF_WIDTH-1:0]    conf_nxt;

    assign l_idx       = vp_index(lookup_pc);
    assign t_idx       = vp_index(train_pc);
    assign l_ent       = entries_q[l_idx];
    assign t_ent       = entries_q[t_idx];
    assign l_hit       = l_ent.valid && l_ent.tag == vp_tag(lookup_pc) && !flush;
    assign t_hit       = t_ent.valid && t_ent.tag == vp_tag(train_pc);
    assign new_stride  = train_value - t_ent.last_value;
    assign stride_same = new_stride == t_ent.stride;

    vp_sat_counter #(.W(CONF_WIDTH)) u_train_conf (
        .cnt (t_ent.conf),
        .inc (stride_same),
        .clr (!stride_same),
        .nxt (conf_nxt)
    );

    always_comb begin
        entries_d = entries_q;
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) entries_d[i].valid = 1'b0;
        end else if (train_valid) begin
            entries_d[t_idx] = t_hit
                ? '{valid: 1'b1, tag: t_ent.tag, last_value: train_value,
                    stride: t_ent.stride ^ (stride_same ? '0 : (t_ent.stride ^ new_stride)),
                    conf: conf_nxt}
                : '{valid: 1'b1, tag: vp_tag(train_pc), last_value: train_value,
                    stride: '0, conf: '0};
        end
    end

    always_comb begin
        pred_valid_d     = lookup_valid;
        pred_hit_d       = lookup_valid && l_hit;
        pred_confident_d = lookup_valid && l_hit && l_ent.conf >= CONF_WIDTH'(CONF_THRESH);
        pred_value_d     = !lookup_valid ? pred_value_q
                         : l_hit ? l_ent.last_value + l_ent.stride : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) entries_q[i].valid <= 1'b0;
            pred_valid_q     <= 1'b0;
            pred_hit_q       <= 1'b0;
            pred_confident_q <= 1'b0;
            pred_value_q     <= '0;
        end else begin
            entries_q        <= entries_d;
            pred_valid_q     <= pred_valid_d;
            pred_hit_q       <= pred_hit_d;
            pred_confident_q <= pred_confident_d;
            pred_value_q     <= pred_value_d;
        end
    end

    assign pred_valid     = pred_valid_q;
    assign pred_hit       = pred_hit_q;
    assign pred_confident = pred_confident_q;
    assign pred_value     = pred_value_q;
endmodule

// File: tb/tb_vp_stride_table.sv
// tb_vp_stride_table: directed and randomized checks of vp_stride_table against a table model.
module tb_vp_stride_table;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_valid, pred_confident, pred_hit;
    logic [31:0] pred_value;
    logic        train_valid = 1'b0;
    logic [31:0] train_pc = '0;
    logic [31:0] train_value = '0;

    int n_cmp = 0;
    int n_fail = 0;

    vp_stride_table dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_value(pred_value),
        .pred_confident(pred_confident), .pred_hit(pred_hit),
        .train_valid(train_valid), .train_pc(train_pc), .train_value(train_value)
    );

    always #5 clk = ~clk;

    // {valid, hit, confident, value}
    logic [34:0] obs;
    assign obs = {pred_valid, pred_hit, pred_confident, pred_value};

    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_last  [64];
    logic [31:0] m_stride[64];
    int          m_conf  [64];
    logic [34:0] exp_vec = '0;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
        exp_vec = '0;
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 ns after the edge.
    task automatic cyc(input bit lv, input logic [31:0] lpc, input bit tv,
                       input logic [31:0] tpc, input logic [31:0] tval, input bit fl);
        int unsigned li, ti;
        bit hit;
        logic [31:0] ns;
        lookup_valid = lv; lookup_pc = lpc;
        train_valid = tv; train_pc = tpc; train_value = tval; flush = fl;
        li = (lpc / 4) % 64;
        ti = (tpc / 4) % 64;
        if (lv) begin
            hit = !fl && m_valid[li] && m_tag[li] == lpc / 256;
            exp_vec = {1'b1, hit, hit && m_conf[li] >= 2, hit ? m_last[li] + m_stride[li] : 32'h0};
        end else begin
            exp_vec = {3'b000, exp_vec[31:0]};
        end
        if (fl) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 0;
        end else if (tv) begin
            if (m_valid[ti] && m_tag[ti] == tpc / 256) begin
                ns = tval - m_last[ti];
                if (ns == m_stride[ti]) m_conf[ti] = (m_conf[ti] == 3) ? 3 : m_conf[ti] + 1;
                else begin m_stride[ti] = ns; m_conf[ti] = 0; end
                m_last[ti] = tval;
            end else begin
                m_valid[ti] = 1; m_tag[ti] = tpc / 256;
                m_last[ti] = tval; m_stride[ti] = 0; m_conf[ti] = 0;
            end
        end
        @(posedge clk);
        #1;
        lookup_valid = 0; train_valid = 0; flush = 0;
    endtask

    task automatic look(input logic [31:0] pc);
        cyc(1, pc, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] v);
        cyc(0, 0, 1, pc, v, 0);
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (obs !== 35'h0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=%h", obs, 35'h0); end
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        look(32'h400);
        n_cmp++;
        if (obs !== {3'b100, 32'h0}) begin n_fail++; $display("FAIL reset_lookup_miss got=%h exp=%h", obs, {3'b100, 32'h0}); end
    endtask

    task automatic test_stride_train();
        train(32'h400, 32'h100);
        train(32'h400, 32'h104);
        train(32'h400, 32'h108);
        cyc(1, 32'h400, 1, 32'h400, 32'h10C, 0);
        n_cmp++;
        if (obs !== {3'b110, 32'h10C}) begin n_fail++; $display("FAIL stride_conf1 got=%h exp=%h", obs, {3'b110, 32'h10C}); end
        look(32'h400);
        n_cmp++;
        if (obs !== {3'b111, 32'h110}) begin n_fail++; $display("FAIL stride_conf2 got=%h exp=%h", obs, {3'b111, 32'h110}); end
        cyc(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== {3'b000, 32'h110}) begin n_fail++; $display("FAIL idle_hold got=%h exp=%h", obs, {3'b000, 32'h110}); end
    endtask

    task automatic test_stride_break();
        train(32'h400, 32'h200);
        look(32'h400);
        n_cmp++;
        if (obs !== {3'b110, 32'h2F4}) begin n_fail++; $display("FAIL stride_break got=%h exp=%h", obs, {3'b110, 32'h2F4}); end
    endtask

    task automatic test_alias();
        train(32'h500, 32'h55);
        look(32'h400);
        n_cmp++;
        if (obs !== {3'b100, 32'h0}) begin n_fail++; $display("FAIL alias_old_miss got=%h exp=%h", obs, {3'b100, 32'h0}); end
        look(32'h500);
        n_cmp++;
        if (obs !== {3'b110, 32'h55}) begin n_fail++; $display("FAIL alias_new_hit got=%h exp=%h", obs, {3'b110, 32'h55}); end
    endtask

    task automatic test_same_cycle();
        train(32'h400, 32'h10);
        cyc(1, 32'h400, 1, 32'h400, 32'h18, 0);
        n_cmp++;
        if (obs !== {3'b110, 32'h10}) begin n_fail++; $display("FAIL same_cycle_old got=%h exp=%h", obs, {3'b110, 32'h10}); end
        look(32'h400);
        n_cmp++;
        if (obs !== {3'b110, 32'h20}) begin n_fail++; $display("FAIL same_cycle_new got=%h exp=%h", obs, {3'b110, 32'h20}); end
    endtask

    task automatic test_wrap();
        train(32'h804, 32'hFFFF_FFF4);
        train(32'h804, 32'hFFFF_FFFC);
        look(32'h804);
        n_cmp++;
        if (obs !== {3'b110, 32'h4}) begin n_fail++; $display("FAIL stride_wrap got=%h exp=%h", obs, {3'b110, 32'h4}); end
        for (int i = 0; i < 4; i++) train(32'h804, 32'h4 + 32'h8 * i);
        look(32'h804);
        n_cmp++;
        if (obs !== {3'b111, 32'h24}) begin n_fail++; $display("FAIL conf_saturate got=%h exp=%h", obs, {3'b111, 32'h24}); end
    endtask

    task automatic test_flush();
        cyc(1, 32'h400, 1, 32'h400, 32'h999, 1);
        n_cmp++;
        if (obs !== {3'b100, 32'h0}) begin n_fail++; $display("FAIL flush_same_lookup got=%h exp=%h", obs, {3'b100, 32'h0}); end
        look(32'h400);
        n_cmp++;
        if (obs !== {3'b100, 32'h0}) begin n_fail++; $display("FAIL flush_train_dropped got=%h exp=%h", obs, {3'b100, 32'h0}); end
        look(32'h804);
        n_cmp++;
        if (obs !== {3'b100, 32'h0}) begin n_fail++; $display("FAIL flush_other_pc got=%h exp=%h", obs, {3'b100, 32'h0}); end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] stride [8];
        logic [31:0] cur [8];
        int k;
        for (int i = 0; i < 8; i++) begin
            pool[i] = {$urandom_range(0, 3) * 32'h100 + $urandom_range(0, 3) * 32'h4 + 32'h1000}
                      | 32'($urandom_range(0, 3));
            stride[i] = 32'($urandom_range(0, 16)) - 32'd8;
            cur[i] = $urandom;
        end
        for (int n = 0; n < 400; n++) begin
            bit lv, tv, fl;
            logic [31:0] lpc;
            k = $urandom_range(0, 7);
            cur[k] = ($urandom_range(0, 9) < 8) ? cur[k] + stride[k] : $urandom;
            lv = $urandom_range(0, 3) != 0;
            tv = $urandom_range(0, 3) != 0;
            fl = $urandom_range(0, 59) == 0;
            lpc = pool[$urandom_range(0, 7)];
            cyc(lv, lpc, tv, pool[k], cur[k], fl);
            n_cmp++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL random[%0d] got=%h exp=%h", n, obs, exp_vec); end
        end
    endtask

    task automatic test_reset_mid();
        train(32'h400, 32'h1);
        train(32'h400, 32'h2);
        look(32'h400);
        lookup_valid = 1; lookup_pc = 32'h400;
        train_valid = 1; train_pc = 32'h400; train_value = 32'h3;
        #2;
        rst_n = 0;
        #1;
        n_cmp++;
        if (obs !== 35'h0) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", obs, 35'h0); end
        @(posedge clk); #1;
        n_cmp++;
        if (obs !== 35'h0) begin n_fail++; $display("FAIL reset_held got=%h exp=%h", obs, 35'h0); end
        lookup_valid = 0; train_valid = 0;
        rst_n = 1;
        model_reset();
        foreach (m_valid[i]) ;
        look(32'h400);
        n_cmp++;
        if (obs !== {3'b100, 32'h0}) begin n_fail++; $display("FAIL reset_table_empty got=%h exp=%h", obs, {3'b100, 32'h0}); end
        look(32'h1000);
        n_cmp++;
        if (obs !== exp_vec) begin n_fail++; $display("FAIL reset_table_empty2 got=%h exp=%h", obs, exp_vec); end
    endtask

    initial begin
        test_reset();
        test_stride_train();
        test_stride_break();
        test_alias();
        test_same_cycle();
        test_wrap();
        test_flush();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
